// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end: takes a WIDTH-bit word over valid/ready and
// emits it one bit per DIV cycles on data_out, qualified by ena_out.
module serial_word_feeder #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic             msb_first,
    input  logic             flush,
    output logic             data_out,
    output logic             ena_out,
    output logic             busy,
    output logic             done
);

    // Handshake: a word transfers on a rising edge where word_valid && word_ready
    // (and flush is low); the source holds word_in/word_valid until then.

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             order_q, order_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            order_q   <= 1'b0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            order_q   <= order_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        order_d   = order_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (word_valid && !flush) begin
                    state_d   = SHIFT;
                    shreg_d   = word_in;
                    order_d   = msb_first;
                    bit_cnt_d = '0;
                    div_cnt_d = DIV_LAST;
                end
            end
            SHIFT: begin
                // flush wins even over the final strobe, so no done is produced
                if (flush) begin
                    state_d   = IDLE;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end else if (div_cnt_q == '0) begin
                    shreg_d   = order_q ? {shreg_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg_q[WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    div_cnt_d = DIV_LAST;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign word_ready = (state_q == IDLE);
    assign busy       = (state_q == SHIFT);
    assign ena_out    = busy && (div_cnt_q == '0);
    assign data_out   = busy && (order_q ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign done       = done_q;

endmodule

// File: doc/serial_word_feeder.md
# serial_word_feeder

Parallel-to-serial front end placed directly upstream of the serial-in/serial-out shift register. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit at a time, MSB-first or LSB-first, on `data_out`. A qualifying `ena_out` strobe marks each bit and drives the downstream register's `data_in`/`ena` pins directly. An optional clock divider stretches the bit period.

## Interface
- `WIDTH`, default 8, word length in bits; must be ≥ 2.
- `DIV`, default 1, clock cycles per serial bit; must be ≥ 1.

- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `word_in`  input  WIDTH  parallel word; sampled only on the accept edge.
- `word_valid`  input  1  `word_in` is valid.
- `word_ready`  output  1  block can accept a word.
- `msb_first`  input  1  bit order, sampled on the accept edge: 1 = bit WIDTH-1 first, 0 = bit 0 first.
- `flush`  input  1  synchronous abort of the word in flight.
- `data_out`  output  1  current serial bit.
- `ena_out`  output  1  one-cycle strobe; `data_out` is valid and is consumed this cycle.
- `busy`  output  1  a word is being serialized.
- `done`  output  1  one-cycle pulse after the last bit of a word.

## Operation
- States:
  - IDLE: `word_ready`=1, `busy`=0, `data_out`=0, `ena_out`=0.
  - SHIFT: `word_ready`=0, `busy`=1.
- Accept happens on a rising edge where `word_valid` && `word_ready`. On that edge:
  - `word_in` is loaded into the shift register and `msb_first` into the order flag.
  - bit_cnt is set to 0 and div_cnt to DIV-1.
  - The state moves to SHIFT.
- In SHIFT:
  - `data_out` = shreg[WIDTH-1] when the order flag is 1, else shreg[0]. It is driven from registers only, with no combinational path from the inputs.
  - `ena_out` = (div_cnt == 0).
  - On an edge with `ena_out`=0, div_cnt decrements.
  - On an edge with `ena_out`=1, the shift register moves one place toward the output end (left if MSB-first, right if LSB-first), 0 fills in, bit_cnt increments, and div_cnt reloads to DIV-1.
  - On the `ena_out` edge where bit_cnt == WIDTH-1, the state returns to IDLE and `done` is registered high for exactly one cycle.
- Counter widths:
  - bit_cnt is $clog2(WIDTH) bits.
  - div_cnt is max(1,$clog2(DIV)) bits.
  - Neither counter wraps inside a word; both reload only as described.
- `flush`=1 on any edge in SHIFT:
  - The state goes to IDLE, the counters clear and the shift register clears.
  - No `done` pulse is produced and no further `ena_out` is issued.
  - `flush` has priority over the final `ena_out` edge.
- `flush` in IDLE has no effect. An accept in the same cycle as `flush` is ignored: `word_ready` holds, the word is not taken, and the source must keep `word_valid` asserted.
- `word_valid` without `word_ready` is held by the source. The block never drops a word after acceptance, except through `flush` or reset.
- `word_in` and `msb_first` changes during SHIFT are ignored.

## Timing
- Reset (`rst`=0, any time, including mid-word) forces:
  - state IDLE, all registers cleared.
  - `word_ready`=1, `busy`=0, `done`=0, `data_out`=0, `ena_out`=0.
  - Release is synchronous to the next edge; the first accept is possible on the first edge after release.
- With accept on edge E0:
  - The first `ena_out` is in the cycle following edge E0+(DIV-1).
  - Strobe k (0-based) is in the cycle following edge E0+k·DIV+(DIV-1).
  - With DIV=1, `ena_out` is high for WIDTH consecutive cycles starting the cycle after E0.
- `done` is high in the cycle after the last `ena_out` cycle. `word_ready` is high in that same cycle, so back-to-back words have exactly one idle cycle between the last bit of one word and the first strobe of the next when DIV=1.
- Throughput is one word per WIDTH·DIV+1 cycles.

## Test plan
- Reset mid-word: WIDTH=8, DIV=1, accept 0xA5, assert `rst` low after 3 strobes -> all outputs 0, `word_ready`=1 immediately; no `done`; next word serializes from its first bit.
- MSB-first, DIV=1: accept 0xA5 with `msb_first`=1 -> `ena_out` high 8 consecutive cycles starting the cycle after accept; `data_out` = 1,0,1,0,0,1,0,1; `done` one cycle later.
- LSB-first, DIV=3: accept 0x0F with `msb_first`=0 -> strobes every 3rd cycle, first on the 3rd cycle after accept; bits 1,1,1,1,0,0,0,0; total 24 cycles busy.
- Back-to-back with stalled source: hold `word_valid`=1 with 0x81 then 0x7E -> second accept in the `done` cycle; exactly one non-strobe cycle between the words' bits; `word_ready`=0 throughout SHIFT.
- Flush: accept 0xFF, assert `flush` on the edge of the 8th strobe -> no `done`, `busy` drops, `data_out`=0; a simultaneous `word_valid` is not accepted until the following cycle.
- Downstream hookup: connect `data_out`/`ena_out` to the 4-bit shift register with matching direction and feed 0xC3 MSB-first -> after the last strobe the register holds 4'b0011.
